// File: rtl/mips_mem_arbiter.sv
// Avalon master arbiter for I-cache refill, D-cache refill and write-buffer drain.
// Instruction reads win over data reads; a read streak counter bounds write starvation.
module mips_mem_arbiter #(
    parameter int unsigned MAX_READ_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_valid,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_valid,

    input  logic        wb_req,
    input  logic        wb_full,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_writedata,
    input  logic [3:0]  wb_byteenable,
    output logic        wb_ack,

    output logic [31:0] readdata,

    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        waitrequest,
    input  logic [31:0] mem_readdata,

    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StInstr = 2'd1,
        StData  = 2'd2,
        StWrite = 2'd3
    } state_e;

    localparam logic [3:0] StreakMax = 4'(MAX_READ_STREAK);

    state_e     state_q, state_d;
    state_e     arb_pick;
    logic [3:0] streak_q, streak_d;
    logic       completion;
    logic       read_done;
    logic       write_done;
    logic       force_write;

    assign completion = (state_q != StIdle) && !waitrequest;
    assign read_done  = completion && ((state_q == StInstr) || (state_q == StData));
    assign write_done = completion && (state_q == StWrite);

    always_comb begin
        streak_d = streak_q;
        if (!wb_req || write_done) begin
            streak_d = 4'd0;
        end else if (read_done && (streak_q < StreakMax)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // The updated count is used so the completing read already counts toward the limit.
    assign force_write = wb_req && (wb_full || (streak_d >= StreakMax));

    always_comb begin
        if (force_write) begin
            arb_pick = StWrite;
        end else if (i_req) begin
            arb_pick = StInstr;
        end else if (d_req) begin
            arb_pick = StData;
        end else if (wb_req) begin
            arb_pick = StWrite;
        end else begin
            arb_pick = StIdle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == StIdle) || completion) begin
            state_d = arb_pick;
        end
    end

    // Bus outputs depend only on the registered state and the held requester fields.
    always_comb begin
        mem_address    = 32'd0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'd0;
        mem_byteenable = 4'd0;
        unique case (state_q)
            StIdle: begin
            end
            StInstr: begin
                mem_read       = 1'b1;
                mem_address    = i_addr;
                mem_byteenable = 4'hF;
            end
            StData: begin
                mem_read       = 1'b1;
                mem_address    = d_addr;
                mem_byteenable = 4'hF;
            end
            StWrite: begin
                mem_write      = 1'b1;
                mem_address    = wb_addr;
                mem_writedata  = wb_writedata;
                mem_byteenable = wb_byteenable;
            end
            default: begin
            end
        endcase
    end

    assign i_valid  = completion && (state_q == StInstr);
    assign d_valid  = completion && (state_q == StData);
    assign wb_ack   = completion && (state_q == StWrite);
    assign readdata = mem_readdata;
    assign grant    = state_q;

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_read && mem_write));

    a_hold_on_wait: assert property (@(posedge clk) disable iff (!rst_n)
        ((state_q != StIdle) && waitrequest) |=> (state_q == $past(state_q)));

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: expected transactions are queued by the stimulus
// and retired by a monitor whenever a response pulse appears.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'd0;
    logic        i_valid;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic        d_valid;
    logic        wb_req = 1'b0;
    logic        wb_full = 1'b0;
    logic [31:0] wb_addr = 32'd0;
    logic [31:0] wb_writedata = 32'd0;
    logic [3:0]  wb_byteenable = 4'd0;
    logic        wb_ack;
    logic [31:0] readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        waitrequest = 1'b0;
    logic [31:0] mem_readdata;
    logic [1:0]  grant;

    // Requesters release their request once served unless a test holds it high.
    bit i_drop = 1'b1;
    bit d_drop = 1'b1;
    bit wb_drop = 1'b1;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [1:0]  mon_k;
    int          tests = 0;
    int          fails = 0;
    logic [1:0]  starve_grants [6];

    always #5 clk = ~clk;

    // Slave model: one fixed boot word, otherwise the inverted address.
    assign mem_readdata = (mem_address == 32'hBFC0_0000) ? 32'h2402_0005 : ~mem_address;

    mips_mem_arbiter #(.MAX_READ_STREAK(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_valid        (i_valid),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_valid        (d_valid),
        .wb_req         (wb_req),
        .wb_full        (wb_full),
        .wb_addr        (wb_addr),
        .wb_writedata   (wb_writedata),
        .wb_byteenable  (wb_byteenable),
        .wb_ack         (wb_ack),
        .readdata       (readdata),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .waitrequest    (waitrequest),
        .mem_readdata   (mem_readdata),
        .grant          (grant)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.be   = b;
        sb.push_back(e);
    endtask

    // One bus cycle: set waitrequest at the falling edge, then retire served requests.
    task automatic cyc(input logic w);
        @(negedge clk);
        waitrequest = w;
        #1;
        if (i_valid && i_drop) i_req = 1'b0;
        if (d_valid && d_drop) d_req = 1'b0;
        if (wb_ack && wb_drop) begin
            wb_req  = 1'b0;
            wb_full = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (i_valid || d_valid || wb_ack) begin
                mon_k = i_valid ? 2'd1 : (d_valid ? 2'd2 : 2'd3);
                check("pulse_onehot", 32'(i_valid) + 32'(d_valid) + 32'(wb_ack), 32'd1);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got kind %0d, expected no pulse", mon_k);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_kind", 32'(mon_k), 32'(mon_e.kind));
                    check("pulse_grant", 32'(grant), 32'(mon_e.kind));
                    check("pulse_addr", mem_address, mon_e.addr);
                    check("pulse_be", 32'(mem_byteenable), 32'(mon_e.be));
                    if (mon_k == 2'd3) begin
                        check("wr_strobe", {30'd0, mem_write, mem_read}, 32'd2);
                        check("wr_data", mem_writedata, mon_e.data);
                    end else begin
                        check("rd_strobe", {30'd0, mem_write, mem_read}, 32'd1);
                        check("rd_data", readdata, mon_e.data);
                        check("rd_wdata_zero", mem_writedata, 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        starve_grants[0] = 2'd2;
        starve_grants[1] = 2'd2;
        starve_grants[2] = 2'd3;
        starve_grants[3] = 2'd2;
        starve_grants[4] = 2'd2;
        starve_grants[5] = 2'd3;

        // Reset held with a pending instruction request.
        #2;
        rst_n  = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'hBFC0_0000;
        cyc(0);
        cyc(0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_read", 32'(mem_read), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_be", 32'(mem_byteenable), 32'd0);
        check("rst_wdata", mem_writedata, 32'd0);
        check("rst_ivalid", 32'(i_valid), 32'd0);

        // Release; instruction read with two wait states.
        push(2'd1, 32'hBFC0_0000, 32'h2402_0005, 4'hF);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        check("ird_w1_read", 32'(mem_read), 32'd1);
        check("ird_w1_addr", mem_address, 32'hBFC0_0000);
        check("ird_w1_grant", 32'(grant), 32'd1);
        cyc(1);
        check("ird_w2_read", 32'(mem_read), 32'd1);
        check("ird_w2_addr", mem_address, 32'hBFC0_0000);
        cyc(0);
        check("ird_w3_read", 32'(mem_read), 32'd1);
        check("ird_w3_addr", mem_address, 32'hBFC0_0000);
        cyc(0);
        check("ird_done_read", 32'(mem_read), 32'd0);
        check("ird_done_grant", 32'(grant), 32'd0);

        // All three requesters at once, zero wait states.
        i_req = 1'b1;  i_addr = 32'h0040_0000;
        d_req = 1'b1;  d_addr = 32'h1001_0000;
        wb_req = 1'b1; wb_addr = 32'h1001_0040;
        wb_writedata = 32'hDEAD_BEEF; wb_byteenable = 4'hF;
        push(2'd1, 32'h0040_0000, 32'hFFBF_FFFF, 4'hF);
        push(2'd2, 32'h1001_0000, 32'hEFFE_FFFF, 4'hF);
        push(2'd3, 32'h1001_0040, 32'hDEAD_BEEF, 4'hF);
        cyc(0);
        check("all3_g1", 32'(grant), 32'd1);
        cyc(0);
        check("all3_g2", 32'(grant), 32'd2);
        cyc(0);
        check("all3_g3", 32'(grant), 32'd3);
        cyc(0);
        check("all3_idle", 32'(grant), 32'd0);

        // Starvation bound with reads and writes held continuously.
        d_drop = 1'b0;
        wb_drop = 1'b0;
        d_req = 1'b1;  d_addr = 32'h1002_0000;
        wb_req = 1'b1; wb_addr = 32'h1003_0000;
        wb_writedata = 32'h0000_BEEF; wb_byteenable = 4'b0011;
        for (int n = 0; n < 6; n++) begin
            if (starve_grants[n] == 2'd3) push(2'd3, 32'h1003_0000, 32'h0000_BEEF, 4'b0011);
            else push(2'd2, 32'h1002_0000, 32'hEFFD_FFFF, 4'hF);
        end
        for (int n = 0; n < 6; n++) begin
            cyc(0);
            check("starve_grant", 32'(grant), 32'(starve_grants[n]));
        end
        d_req = 1'b0;
        wb_req = 1'b0;
        d_drop = 1'b1;
        wb_drop = 1'b1;
        cyc(0);
        check("starve_idle", 32'(grant), 32'd0);

        // Full write buffer beats a pending instruction read.
        i_req = 1'b1;  i_addr = 32'h0040_0010;
        wb_req = 1'b1; wb_full = 1'b1; wb_addr = 32'h1004_0000;
        wb_writedata = 32'h1234_5678; wb_byteenable = 4'b1100;
        push(2'd3, 32'h1004_0000, 32'h1234_5678, 4'b1100);
        push(2'd1, 32'h0040_0010, 32'hFFBF_FFEF, 4'hF);
        cyc(1);
        check("full_g_wait", 32'(grant), 32'd3);
        check("full_no_ack", 32'(wb_ack), 32'd0);
        cyc(0);
        check("full_g_wr", 32'(grant), 32'd3);
        cyc(0);
        check("full_g_rd", 32'(grant), 32'd1);
        cyc(0);
        check("full_idle", 32'(grant), 32'd0);

        // Reset asserted in the middle of a stalled read.
        i_req = 1'b1; i_addr = 32'h0040_0020;
        cyc(1);
        check("mid_read", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_read", 32'(mem_read), 32'd0);
        check("mid_rst_addr", mem_address, 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_ivalid", 32'(i_valid), 32'd0);
        cyc(0);
        check("mid_rst_hold", 32'(mem_read), 32'd0);
        push(2'd1, 32'h0040_0020, 32'hFFBF_FFDF, 4'hF);
        rst_n = 1'b1;
        cyc(0);
        check("reissue_grant", 32'(grant), 32'd1);
        check("reissue_addr", mem_address, 32'h0040_0020);
        cyc(0);
        check("reissue_idle", 32'(grant), 32'd0);

        cyc(0);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
